// File: rtl/garo_pkg.sv
// Shared types and constants for the garo_arbiter entropy-sharing block.
package garo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DELIVER = 2'd2
  } garo_state_e;

  localparam int RND_W         = 8;
  localparam int SPC_W         = 4;
  localparam int CNT_W         = 3;
  localparam int NUM_REQ_DEF   = 4;
  localparam int OUT_BYTES_DEF = 2;
  localparam int SPACING_DEF   = 4;
  localparam int REP_LIMIT_DEF = 8;

endpackage

// File: rtl/garo_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      idx,
  output logic               valid
);

  int            j;
  logic [PW-1:0] j_idx;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    j_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      j_idx = PW'(j);
      if (!valid && req[j_idx]) begin
        valid      = 1'b1;
        gnt[j_idx] = 1'b1;
        idx        = j_idx;
      end
    end
  end

endmodule

// File: rtl/garo_arbiter.sv
// Round-robin sharing of one 8-bit entropy source; OUT_BYTES spaced samples per word.
// Optional repetition-count health test enabled with `define GARO_HEALTH_EN.
module garo_arbiter
  import garo_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int OUT_BYTES = OUT_BYTES_DEF,
  parameter int SPACING   = SPACING_DEF,
  parameter int REP_LIMIT = REP_LIMIT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RND_W-1:0]           rnd_in,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         ack,
  output logic [RND_W*OUT_BYTES-1:0] rnd_out,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic                       fault
);

  localparam int PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WORD_W = RND_W * OUT_BYTES;

  garo_state_e        state_q, state_n;
  logic [PW-1:0]      ptr_q, ptr_n, own_q, own_n, own_inc;
  logic [NUM_REQ-1:0] gnt_q, gnt_n, pick_gnt;
  logic [PW-1:0]      pick_idx;
  logic               pick_vld;
  logic [SPC_W-1:0]   spc_q, spc_n;
  logic [CNT_W-1:0]   nb_q, nb_n;
  logic [WORD_W-1:0]  shr_q, shr_n, word_q, word_n, shr_cap;
  logic               cap, trip, fault_q;

  rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  assign own_inc = (own_q == PW'(NUM_REQ - 1)) ? '0 : own_q + 1'b1;
  assign cap     = (state_q == ST_COLLECT) && (spc_q == '0) && req[own_q];
  assign shr_cap = (shr_q << RND_W) | WORD_W'(rnd_in);

`ifdef GARO_HEALTH_EN
  localparam int RW = $clog2(REP_LIMIT + 1);
  logic [RND_W-1:0] last_q;
  logic [RW-1:0]    rep_q, rep_n;

  // Zero repeat count means no sample has been captured since reset.
  always_comb begin
    rep_n = rep_q;
    if (cap) rep_n = (rep_q != '0 && rnd_in == last_q) ? rep_q + 1'b1 : RW'(1);
  end

  assign trip = cap && (rep_n == RW'(REP_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= '0;
      rep_q   <= '0;
      fault_q <= 1'b0;
    end else if (cap) begin
      last_q <= rnd_in;
      rep_q  <= rep_n;
      if (trip) fault_q <= 1'b1;
    end
  end
`else
  assign trip    = 1'b0;
  assign fault_q = 1'b0;
`endif

  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    own_n   = own_q;
    gnt_n   = gnt_q;
    spc_n   = spc_q;
    nb_n    = nb_q;
    shr_n   = shr_q;
    word_n  = word_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld && !fault_q) begin
          gnt_n   = pick_gnt;
          own_n   = pick_idx;
          spc_n   = SPC_W'(SPACING - 1);
          nb_n    = '0;
          state_n = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        // A dropped request or a health trip abandons the partial word.
        if (!req[own_q] || trip) begin
          gnt_n   = '0;
          ptr_n   = own_inc;
          state_n = ST_IDLE;
        end else if (spc_q == '0) begin
          shr_n = shr_cap;
          nb_n  = nb_q + 1'b1;
          spc_n = SPC_W'(SPACING - 1);
          if (nb_q == CNT_W'(OUT_BYTES - 1)) begin
            word_n  = shr_cap;
            state_n = ST_DELIVER;
          end
        end else begin
          spc_n = spc_q - 1'b1;
        end
      end
      ST_DELIVER: begin
        gnt_n   = '0;
        ptr_n   = own_inc;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      gnt_q   <= '0;
      spc_q   <= '0;
      nb_q    <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      own_q   <= own_n;
      gnt_q   <= gnt_n;
      spc_q   <= spc_n;
      nb_q    <= nb_n;
      word_q  <= word_n;
    end
  end

  // Partial samples are always flushed by OUT_BYTES shifts, so no reset is needed.
  always_ff @(posedge clk) begin
    shr_q <= shr_n;
  end

  assign ack     = (state_q == ST_DELIVER && !rst) ? gnt_q : '0;
  assign gnt     = gnt_q;
  assign rnd_out = word_q;
  assign busy    = (state_q != ST_IDLE);
  assign fault   = fault_q;

endmodule

// File: tb/tb_garo_arbiter.sv
// Randomized and directed checks of garo_arbiter against a grant-age reference model.
module tb_garo_arbiter;

  localparam int N       = 4;
  localparam int OB      = 2;
  localparam int SP      = 4;
  localparam int RL      = 8;
  localparam int WW      = 8 * OB;
  localparam int DLV_AGE = OB * SP + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rnd_in = '0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  ack, gnt;
  logic [WW-1:0] rnd_out;
  logic          busy, fault;

  garo_arbiter #(.NUM_REQ(N), .OUT_BYTES(OB), .SPACING(SP), .REP_LIMIT(RL)) dut (
    .clk     (clk),
    .rst     (rst),
    .rnd_in  (rnd_in),
    .req     (req),
    .ack     (ack),
    .rnd_out (rnd_out),
    .gnt     (gnt),
    .busy    (busy),
    .fault   (fault)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: owner index and cycles elapsed since its grant.
  int            m_owner = -1;
  int            m_age   = 0;
  int            m_ptr   = 0;
  int            m_rep   = 0;
  logic [7:0]    m_last  = '0;
  bit            m_fault = 1'b0;
  logic [WW-1:0] m_word  = '0;
  byte unsigned  m_samp[$];

  function automatic logic [N-1:0] e_gnt();
    return (m_owner >= 0) ? N'(1 << m_owner) : '0;
  endfunction

  function automatic logic [N-1:0] e_ack();
    return (m_owner >= 0 && m_age == DLV_AGE && !rst) ? e_gnt() : '0;
  endfunction

  task automatic m_step(input logic r, input logic [N-1:0] q, input logic [7:0] d);
    if (r) begin
      m_owner = -1; m_age = 0; m_ptr = 0; m_word = '0;
      m_fault = 1'b0; m_rep = 0; m_last = '0; m_samp.delete();
    end else if (m_owner < 0) begin
      if (!m_fault) begin
        for (int i = 0; i < N; i++) begin
          int j;
          j = (m_ptr + i) % N;
          if (q[j]) begin
            m_owner = j; m_age = 1; m_samp.delete();
            break;
          end
        end
      end
    end else if (m_age == DLV_AGE || !q[m_owner]) begin
      m_ptr = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
      if (m_age % SP == 0) begin
        m_samp.push_back(d);
`ifdef GARO_HEALTH_EN
        m_rep = (m_rep != 0 && d == m_last) ? m_rep + 1 : 1;
        m_last = d;
        if (m_rep == RL) begin
          m_fault = 1'b1;
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
          return;
        end
`endif
        if (m_samp.size() == OB) begin
          m_word = '0;
          foreach (m_samp[k]) m_word = (m_word << 8) | WW'(m_samp[k]);
        end
      end
      m_age++;
    end
  endtask

  int cyc = 0;
  int ack_cyc[$];
  int ack_idx[$];

  task automatic tick(input logic r, input logic [N-1:0] q, input logic [7:0] d, input bit cmp);
    @(negedge clk);
    cyc++;
    if (cmp) begin
      check("gnt", 32'(gnt), 32'(e_gnt()));
      check("ack", 32'(ack), 32'(e_ack()));
      check("rnd_out", 32'(rnd_out), 32'(m_word));
      check("busy", 32'(busy), 32'(m_owner >= 0));
      check("fault", 32'(fault), 32'(m_fault));
      check("gnt_onehot", 32'($countones(gnt)), 32'(m_owner >= 0));
    end
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        ack_cyc.push_back(cyc);
        ack_idx.push_back(i);
      end
    end
    rst = r; req = q; rnd_in = d;
    m_step(r, q, d);
  endtask

  logic [N-1:0] held;
  logic [7:0]   step_v;
  int           c0;
  bit           seen2;

  initial begin
    tick(1'b1, '0, 8'h00, 1'b0);
    tick(1'b1, '0, 8'h00, 1'b0);
    tick(1'b1, '0, 8'h00, 1'b1);
    tick(1'b0, '0, 8'h00, 1'b1);

    // Single requester, stepping source, latency measured from the req edge.
    ack_cyc.delete(); ack_idx.delete();
    held = 4'b0001; step_v = 8'h11;
    tick(1'b0, held, step_v, 1'b1);
    c0 = cyc;
    for (int k = 0; k < 20; k++) begin
      held = held & ~e_ack();
      step_v = step_v + 8'h11;
      tick(1'b0, held, step_v, 1'b1);
    end
    if (ack_cyc.size() == 0) check("lat_timeout", 32'd0, 32'd1);
    else begin
      check("lat_cycles", 32'(ack_cyc[0] - c0), 32'(DLV_AGE));
      check("lat_idx", 32'(ack_idx[0]), 32'd0);
    end

    // All four requesting continuously from a reset pointer.
    tick(1'b1, '0, 8'h00, 1'b1);
    ack_cyc.delete(); ack_idx.delete();
    for (int k = 0; k < 60; k++) tick(1'b0, 4'b1111, 8'($urandom), 1'b1);
    check("rr_count_ge5", 32'(ack_cyc.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < ack_cyc.size(); k++) begin
      check("rr_order", 32'(ack_idx[k]), 32'(k % N));
      if (k > 0) check("rr_period", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'(OB * SP + 2));
    end

    // Owner 2 drops mid-collection while 3 waits.
    tick(1'b1, '0, 8'h00, 1'b1);
    ack_cyc.delete(); ack_idx.delete();
    tick(1'b0, 4'b0100, 8'($urandom), 1'b1);
    tick(1'b0, 4'b1100, 8'($urandom), 1'b1);
    tick(1'b0, 4'b1100, 8'($urandom), 1'b1);
    held = 4'b1000;
    for (int k = 0; k < 20; k++) begin
      held = held & ~e_ack();
      tick(1'b0, held, 8'($urandom), 1'b1);
    end
    seen2 = 1'b0;
    foreach (ack_idx[k]) if (ack_idx[k] == 2) seen2 = 1'b1;
    check("abort_no_ack2", 32'(seen2), 32'd0);
    check("abort_ack3_count", 32'(ack_idx.size()), 32'd1);

    // Reset pulse mid-collection.
    ack_cyc.delete(); ack_idx.delete();
    for (int k = 0; k < 4; k++) tick(1'b0, 4'b0001, 8'($urandom), 1'b1);
    tick(1'b1, 4'b0001, 8'h00, 1'b1);
    tick(1'b0, '0, 8'h00, 1'b1);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rnd_out", 32'(rnd_out), 32'd0);
    for (int k = 0; k < 12; k++) tick(1'b0, '0, 8'($urandom), 1'b1);
    check("rst_no_ack", 32'(ack_cyc.size()), 32'd0);

    // Randomized traffic with occasional drops and resets.
    held = '0;
    for (int k = 0; k < 600; k++) begin
      logic [N-1:0] a;
      a = e_ack();
      for (int i = 0; i < N; i++) begin
        if (!held[i]) held[i] = ($urandom_range(3) == 0);
        else if (a[i]) held[i] = $urandom_range(1);
        else if ($urandom_range(31) == 0) held[i] = 1'b0;
      end
      tick(($urandom_range(199) == 0), held, 8'($urandom), 1'b1);
    end

    // Source stuck at 0xA5.
    tick(1'b1, '0, 8'h00, 1'b1);
    ack_cyc.delete(); ack_idx.delete();
    for (int k = 0; k < 60; k++) tick(1'b0, 4'b1111, 8'hA5, 1'b1);
`ifdef GARO_HEALTH_EN
    check("stuck_ack_count", 32'(ack_cyc.size()), 32'd3);
    check("stuck_fault", 32'(fault), 32'd1);
    check("stuck_idle", 32'(busy), 32'd0);
    tick(1'b1, '0, 8'h00, 1'b1);
    tick(1'b0, '0, 8'h00, 1'b1);
    check("fault_cleared", 32'(fault), 32'd0);
`else
    check("stuck_ack_ge5", 32'(ack_cyc.size() >= 5), 32'd1);
    check("stuck_word", 32'(rnd_out), 32'hA5A5);
    check("stuck_no_fault", 32'(fault), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
